// File: rtl/sd_pkg.sv
// Shared types and constants for the SD sector streamer: sector size, FSM states and the
// sector address type.
package sd_pkg;

    localparam int unsigned SECTOR_WORDS = 256;

    typedef enum logic [2:0] {
        StIdle,
        StWaitInit,
        StWaitRoom,
        StIssue,
        StWaitHi,
        StWaitLo,
        StDone
    } sd_state_e;

    typedef logic [31:0] sd_sec_addr_t;

endpackage

// File: rtl/sd_sector_streamer_if.sv
// Bundle of the SD controller read port and the downstream FIFO write port as seen by
// the streamer (master) and by the controller/FIFO side (slave).
interface sd_sector_streamer_if
    import sd_pkg::*;
#(
    parameter int unsigned FREE_W = 12
) ();

    logic              rd_start_en;
    sd_sec_addr_t      rd_sec_addr;
    logic              rd_busy;
    logic              rd_val_en;
    logic [15:0]       rd_val_data;
    logic [FREE_W-1:0] fifo_free;
    logic              out_valid;
    logic [15:0]       out_data;

    modport master (
        output rd_start_en, rd_sec_addr, out_valid, out_data,
        input  rd_busy, rd_val_en, rd_val_data, fifo_free
    );

    modport slave (
        input  rd_start_en, rd_sec_addr, out_valid, out_data,
        output rd_busy, rd_val_en, rd_val_data, fifo_free
    );

endinterface

// File: rtl/sd_sector_streamer.sv
// Reads a contiguous run of SD sectors, drops an optional leading header and streams the
// remaining 16-bit words into a downstream FIFO, one whole sector at a time.
module sd_sector_streamer
    import sd_pkg::*;
#(
    parameter int unsigned HDR_WORDS = 27,
    parameter int unsigned FREE_W    = 12,
    parameter int unsigned BUSY_TO   = 1023,
    parameter int unsigned BYTE_SWAP = 0
) (
    input  logic                        i_clk_ref,
    input  logic                        i_rst,
    input  logic                        i_sd_init_done,
    input  logic                        i_start,
    input  sd_sec_addr_t                i_start_sec_addr,
    input  logic [23:0]                 i_sec_num,
    sd_sector_streamer_if.master        io_bus,
    output logic                        o_busy,
    output logic                        o_run_done,
    output logic                        o_sec_err
);

    localparam int unsigned     TO_W     = (BUSY_TO < 2) ? 1 : $clog2(BUSY_TO + 1);
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(BUSY_TO);
    localparam logic [FREE_W-1:0] ROOM_MIN = FREE_W'(SECTOR_WORDS);
    localparam logic [8:0]      SEC_CNT  = 9'(SECTOR_WORDS);
    localparam logic [7:0]      HDR_INIT = 8'(HDR_WORDS);

    sd_state_e    r_state;
    sd_sec_addr_t r_addr;
    logic [23:0]  r_remain;
    logic [7:0]   r_hdr_cnt;
    logic [8:0]   r_word_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic         r_rd_start_en;
    logic         r_out_valid;
    logic [15:0]  r_out_data;
    logic         r_busy;
    logic         r_run_done;
    logic         r_sec_err;

    logic [8:0]   w_word_cnt_nxt;
    logic [15:0]  w_word;
    logic         w_room;

    always_comb begin
        w_word_cnt_nxt = r_word_cnt;
        if (io_bus.rd_val_en && (r_word_cnt != 9'h1FF)) begin
            w_word_cnt_nxt = r_word_cnt + 9'd1;
        end
        w_word = (BYTE_SWAP != 0) ? {io_bus.rd_val_data[7:0], io_bus.rd_val_data[15:8]}
                                  : io_bus.rd_val_data;
        w_room = (io_bus.fifo_free >= ROOM_MIN);
    end

    always_ff @(posedge i_clk_ref or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_addr        <= '0;
            r_remain      <= '0;
            r_hdr_cnt     <= '0;
            r_word_cnt    <= '0;
            r_to_cnt      <= '0;
            r_rd_start_en <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_busy        <= 1'b0;
            r_run_done    <= 1'b0;
            r_sec_err     <= 1'b0;
        end else begin
            r_rd_start_en <= 1'b0;
            r_out_valid   <= 1'b0;
            r_run_done    <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_addr    <= i_start_sec_addr;
                        r_remain  <= i_sec_num;
                        r_hdr_cnt <= HDR_INIT;
                        r_sec_err <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= (i_sec_num == 24'd0) ? StDone : StWaitInit;
                    end
                end
                StWaitInit: begin
                    if (i_sd_init_done) r_state <= StWaitRoom;
                end
                StWaitRoom: begin
                    // The read port cannot stall mid-sector, so a whole sector must fit.
                    if (w_room && !io_bus.rd_busy && i_sd_init_done) begin
                        r_rd_start_en <= 1'b1;
                        r_state       <= StIssue;
                    end
                end
                StIssue: begin
                    r_to_cnt <= '0;
                    r_state  <= StWaitHi;
                end
                StWaitHi: begin
                    if (io_bus.rd_busy) begin
                        r_word_cnt <= '0;
                        r_state    <= StWaitLo;
                    end else if (r_to_cnt == TO_MAX) begin
                        r_rd_start_en <= 1'b1;
                        r_state       <= StIssue;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                StWaitLo: begin
                    if (io_bus.rd_val_en) begin
                        r_word_cnt <= w_word_cnt_nxt;
                        if (r_hdr_cnt != 8'd0) begin
                            r_hdr_cnt <= r_hdr_cnt - 8'd1;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_word;
                        end
                    end
                    // Entered only with rd_busy high, so low here is the falling edge.
                    if (!io_bus.rd_busy) begin
                        if (w_word_cnt_nxt != SEC_CNT) r_sec_err <= 1'b1;
                        r_addr   <= r_addr + 32'd1;
                        r_remain <= r_remain - 24'd1;
                        r_state  <= (r_remain == 24'd1) ? StDone : StWaitRoom;
                    end
                end
                StDone: begin
                    r_run_done <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.rd_start_en = r_rd_start_en;
    assign io_bus.rd_sec_addr = r_addr;
    assign io_bus.out_valid   = r_out_valid;
    assign io_bus.out_data    = r_out_data;
    assign o_busy             = r_busy;
    assign o_run_done         = r_run_done;
    assign o_sec_err          = r_sec_err;

endmodule

// File: tb/tb_sd_sector_streamer.sv
// Directed bench for sd_sector_streamer: a default-parameter instance driven by a small SD
// read model and scoreboard, plus a byte-swap/no-header instance for the latency check.
module tb_sd_sector_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        init;
    logic        start_a, start_b;
    logic [31:0] saddr_a, saddr_b;
    logic [23:0] num_a, num_b;
    logic        busy_a, done_a, err_a;
    logic        busy_b, done_b, err_b;

    sd_sector_streamer_if #(.FREE_W(12)) bus_a ();
    sd_sector_streamer_if #(.FREE_W(12)) bus_b ();

    sd_sector_streamer dut_a (
        .i_clk_ref       (clk),
        .i_rst           (rst),
        .i_sd_init_done  (init),
        .i_start         (start_a),
        .i_start_sec_addr(saddr_a),
        .i_sec_num       (num_a),
        .io_bus          (bus_a),
        .o_busy          (busy_a),
        .o_run_done      (done_a),
        .o_sec_err       (err_a)
    );

    sd_sector_streamer #(
        .HDR_WORDS(0),
        .BYTE_SWAP(1)
    ) dut_b (
        .i_clk_ref       (clk),
        .i_rst           (rst),
        .i_sd_init_done  (init),
        .i_start         (start_b),
        .i_start_sec_addr(saddr_b),
        .i_sec_num       (num_b),
        .io_bus          (bus_b),
        .o_busy          (busy_b),
        .o_run_done      (done_b),
        .o_sec_err       (err_b)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_pulse = 0;
    int n_out = 0;
    int n_done = 0;
    int data_err = 0;
    int n_out_b = 0;
    int hdr_left = 0;
    logic [15:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_a.rd_start_en) n_pulse++;
        if (done_a) n_done++;
        if (bus_b.out_valid) n_out_b++;
        if (bus_a.out_valid) begin
            n_out++;
            if (exp_q.size() == 0) begin
                data_err++;
            end else begin
                if (exp_q[0] !== bus_a.out_data) data_err++;
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run_a(input logic [31:0] a, input logic [23:0] n);
        @(posedge clk); #1;
        start_a = 1'b1;
        saddr_a = a;
        num_a   = n;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic wait_pulse_a(input string tag, output logic [31:0] addr, output int c);
        logic seen;
        seen = 1'b0;
        addr = '0;
        c    = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus_a.rd_start_en) begin
                seen = 1'b1;
                addr = bus_a.rd_sec_addr;
                c    = cyc;
                break;
            end
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic send_words(input int n, input logic [15:0] base, input bit push);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            w = base + 16'(i);
            bus_a.rd_val_en   = 1'b1;
            bus_a.rd_val_data = w;
            if (push) begin
                if (hdr_left > 0) hdr_left--;
                else exp_q.push_back(w);
            end
        end
        @(posedge clk); #1;
        bus_a.rd_val_en = 1'b0;
    endtask

    task automatic deliver_a(input int n, input logic [15:0] base);
        @(posedge clk); #1;
        bus_a.rd_busy = 1'b1;
        tick(2);
        send_words(n, base, 1'b1);
        @(posedge clk); #1;
        bus_a.rd_busy = 1'b0;
    endtask

    task automatic wait_idle_a(input string tag);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy_a) begin
                idle = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        check_eq(tag, 32'(idle), 32'd1);
    endtask

    logic [31:0] a1, a2;
    int c1, c2, p0, o0, d0;
    logic seen_b;

    initial begin
        rst = 1'b1; init = 1'b0;
        start_a = 1'b0; saddr_a = '0; num_a = '0;
        start_b = 1'b0; saddr_b = '0; num_b = '0;
        bus_a.rd_busy = 1'b0; bus_a.rd_val_en = 1'b0; bus_a.rd_val_data = '0;
        bus_a.fifo_free = 12'd300;
        bus_b.rd_busy = 1'b0; bus_b.rd_val_en = 1'b0; bus_b.rd_val_data = '0;
        bus_b.fifo_free = 12'd300;
        tick(3);
        check_eq("rst_ctl", 32'({busy_a, done_a, err_a, bus_a.rd_start_en, bus_a.out_valid}), 0);
        check_eq("rst_addr", bus_a.rd_sec_addr, 32'd0);
        check_eq("rst_data", 32'(bus_a.out_data), 32'd0);
        rst = 1'b0;
        tick(2);

        // Init gating, plus a start while busy that must be ignored.
        hdr_left = 27; p0 = n_pulse; o0 = n_out; d0 = n_done;
        start_run_a(32'h2000, 24'd2);
        tick(500);
        check_eq("init_gate", 32'(n_pulse - p0), 32'd0);
        check_eq("init_busy", 32'(busy_a), 32'd1);
        start_run_a(32'h9999, 24'd5);
        init = 1'b1;
        wait_pulse_a("init_p0", a1, c1);
        check_eq("init_addr0", a1, 32'h2000);
        deliver_a(256, 16'h1000);
        wait_pulse_a("init_p1", a1, c1);
        check_eq("init_addr1", a1, 32'h2001);
        deliver_a(256, 16'h2000);
        wait_idle_a("init_idle");
        check_eq("init_pulses", 32'(n_pulse - p0), 32'd2);
        check_eq("init_outs", 32'(n_out - o0), 32'd485);
        check_eq("init_done", 32'(n_done - d0), 32'd1);
        check_eq("init_err", 32'(err_a), 32'd0);
        check_eq("init_data", 32'(data_err), 32'd0);

        // Byte swap with no header: exactly one cycle of latency.
        @(posedge clk); #1;
        start_b = 1'b1; saddr_b = 32'h5; num_b = 24'd1;
        @(posedge clk); #1;
        start_b = 1'b0;
        seen_b = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_b.rd_start_en) begin
                seen_b = 1'b1;
                break;
            end
        end
        check_eq("swap_pulse", 32'(seen_b), 32'd1);
        @(posedge clk); #1;
        bus_b.rd_busy = 1'b1;
        tick(2);
        bus_b.rd_val_en = 1'b1; bus_b.rd_val_data = 16'hA1B2;
        @(negedge clk);
        check_eq("swap_lat0", 32'(bus_b.out_valid), 32'd0);
        @(posedge clk); #1;
        bus_b.rd_val_en = 1'b0;
        @(negedge clk);
        check_eq("swap_valid", 32'(bus_b.out_valid), 32'd1);
        check_eq("swap_data", 32'(bus_b.out_data), 32'h0000B2A1);
        for (int i = 0; i < 255; i++) begin
            @(posedge clk); #1;
            bus_b.rd_val_en = 1'b1; bus_b.rd_val_data = 16'(i);
        end
        @(posedge clk); #1;
        bus_b.rd_val_en = 1'b0;
        @(posedge clk); #1;
        bus_b.rd_busy = 1'b0;
        tick(10);
        check_eq("swap_outs", 32'(n_out_b), 32'd256);
        check_eq("swap_busy", 32'(busy_b), 32'd0);
        check_eq("swap_err", 32'(err_b), 32'd0);

        // Back-pressure, including the 255/256 free-slot boundary.
        bus_a.fifo_free = 12'd200;
        hdr_left = 27; p0 = n_pulse; o0 = n_out;
        start_run_a(32'h3000, 24'd1);
        tick(1000);
        check_eq("bp_200", 32'(n_pulse - p0), 32'd0);
        bus_a.fifo_free = 12'd255;
        tick(50);
        check_eq("bp_255", 32'(n_pulse - p0), 32'd0);
        bus_a.fifo_free = 12'd256;
        wait_pulse_a("bp_p0", a1, c1);
        check_eq("bp_addr", a1, 32'h3000);
        deliver_a(256, 16'h3000);
        wait_idle_a("bp_idle");
        check_eq("bp_outs", 32'(n_out - o0), 32'd229);
        bus_a.fifo_free = 12'd300;

        // Timeout retry: the first pulse goes unanswered.
        hdr_left = 27; o0 = n_out; d0 = n_done;
        start_run_a(32'h10, 24'd1);
        wait_pulse_a("to_p0", a1, c1);
        wait_pulse_a("to_p1", a2, c2);
        check_eq("to_addr0", a1, 32'h10);
        check_eq("to_addr1", a2, 32'h10);
        check_eq("to_gap", 32'((c2 - c1) >= 1023 && (c2 - c1) <= 1026), 32'd1);
        deliver_a(256, 16'h0100);
        wait_idle_a("to_idle");
        check_eq("to_done", 32'(n_done - d0), 32'd1);
        check_eq("to_outs", 32'(n_out - o0), 32'd229);

        // Short middle sector sets a sticky error.
        hdr_left = 27; o0 = n_out; d0 = n_done;
        start_run_a(32'h500, 24'd3);
        wait_pulse_a("sh_p0", a1, c1);
        deliver_a(256, 16'h5000);
        wait_pulse_a("sh_p1", a1, c1);
        deliver_a(255, 16'h5100);
        wait_pulse_a("sh_p2", a1, c1);
        check_eq("sh_addr2", a1, 32'h502);
        check_eq("sh_err_mid", 32'(err_a), 32'd1);
        deliver_a(256, 16'h5200);
        wait_idle_a("sh_idle");
        check_eq("sh_err_end", 32'(err_a), 32'd1);
        check_eq("sh_done", 32'(n_done - d0), 32'd1);
        check_eq("sh_outs", 32'(n_out - o0), 32'd740);
        check_eq("sh_data", 32'(data_err), 32'd0);

        // Empty run; its accepted start also clears the sticky error.
        p0 = n_pulse; d0 = n_done;
        start_run_a(32'h77, 24'd0);
        wait_idle_a("empty_idle");
        check_eq("empty_done", 32'(n_done - d0), 32'd1);
        check_eq("empty_pulses", 32'(n_pulse - p0), 32'd0);
        check_eq("empty_err", 32'(err_a), 32'd0);

        // Reset in the middle of a sector.
        hdr_left = 27;
        start_run_a(32'h40, 24'd2);
        wait_pulse_a("rs_p0", a1, c1);
        check_eq("rs_addr", a1, 32'h40);
        @(posedge clk); #1;
        bus_a.rd_busy = 1'b1;
        tick(2);
        send_words(100, 16'h4000, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rs_ctl", 32'({busy_a, done_a, err_a, bus_a.rd_start_en, bus_a.out_valid}), 0);
        check_eq("rs_sec_addr", bus_a.rd_sec_addr, 32'd0);
        check_eq("rs_data", 32'(data_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        o0 = n_out; p0 = n_pulse;
        send_words(156, 16'h4100, 1'b0);
        @(posedge clk); #1;
        bus_a.rd_busy = 1'b0;
        tick(20);
        check_eq("rs_no_out", 32'(n_out - o0), 32'd0);
        check_eq("rs_no_pulse", 32'(n_pulse - p0), 32'd0);
        check_eq("rs_idle", 32'(busy_a), 32'd0);

        // Clean run after the reset.
        hdr_left = 27; o0 = n_out; d0 = n_done;
        start_run_a(32'h80, 24'd1);
        wait_pulse_a("cl_p0", a1, c1);
        check_eq("cl_addr", a1, 32'h80);
        deliver_a(256, 16'h8000);
        wait_idle_a("cl_idle");
        check_eq("cl_outs", 32'(n_out - o0), 32'd229);
        check_eq("cl_done", 32'(n_done - d0), 32'd1);
        check_eq("cl_err", 32'(err_a), 32'd0);
        check_eq("cl_data", 32'(data_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
